// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared types and constants for the two-port SRAM arbiter.
//                - state_t    : arbiter FSM states (INIT zero-fill, SERVE)
//                - NUM_PORTS  : number of requesting ports
//                - port_idx_t : index type wide enough for one port number
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arbiter_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage : sram_arbiter_pkg
`default_nettype wire

// File: rtl/sram.sv
`default_nettype none
// ============================================================================
//  Module      : sram
//  Description : Single-port synchronous SRAM with a registered read port.
//                Neither the array nor the output register is reset.
//  Ports       : i_clk   - clock, rising edge
//                i_write - 1 = write i_data to i_addr, 0 = read i_addr
//                i_addr  - word address
//                i_data  - write data
//                o_data  - read data, valid the cycle after a read
//  Revision    : 1.0  initial release
// ============================================================================
module sram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // The output register only updates on reads, so it keeps the last read
    // word across writes.
    always_ff @(posedge i_clk) begin
        if (i_write) begin
            r_mem[i_addr] <= i_data;
        end else begin
            o_data <= r_mem[i_addr];
        end
    end

endmodule : sram
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Zero-fills an sram after reset, then shares its single port
//                between two valid/ready requesters with round-robin
//                arbitration. Reads return one cycle after the grant.
//  Ports       : i_clk        - clock, rising edge
//                i_rst_n      - asynchronous active-low reset
//                i_req_valid  - per-port request valid
//                i_req_write  - per-port op (1 = write, 0 = read)
//                i_req_addr   - per-port address, port k at [k*AW +: AW]
//                i_req_wdata  - per-port write data, port k at [k*DW +: DW]
//                o_req_ready  - per-port grant, one-hot or zero
//                o_rsp_valid  - per-port read response strobe
//                o_rsp_data   - read data shared by both ports
//                o_init_done  - high once zero-fill has completed
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_PORTS-1:0]            i_req_valid,
    input  logic [NUM_PORTS-1:0]            i_req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_PORTS-1:0]            o_req_ready,
    output logic [NUM_PORTS-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_data,
    output logic                            o_init_done
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // One bit wider than the address so the terminal value never wraps.
    localparam logic [ADDR_WIDTH:0] c_last_addr = (ADDR_WIDTH+1)'(DEPTH-1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH:0]    r_init_addr;
    port_idx_t              r_last_grant;
    logic                   r_rsp_vld;
    port_idx_t              r_rsp_port;

    logic                   w_any_gnt;
    port_idx_t              w_gnt_port;
    logic                   w_gnt_write;
    logic                   w_mem_write;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0]  w_mem_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, arbitration and memory port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        w_gnt_port  = '0;
        w_mem_write = 1'b0;
        w_mem_addr  = r_init_addr[ADDR_WIDTH-1:0];
        w_mem_data  = '0;

        case (r_state)
            INIT: begin
                w_mem_write = 1'b1;
                if (r_init_addr == c_last_addr) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                case (i_req_valid)
                    2'b01: begin
                        o_req_ready = 2'b01;
                        w_gnt_port  = port_idx_t'(0);
                    end
                    2'b10: begin
                        o_req_ready = 2'b10;
                        w_gnt_port  = port_idx_t'(1);
                    end
                    2'b11: begin
                        // Tie goes to the port not granted most recently.
                        if (r_last_grant == port_idx_t'(1)) begin
                            o_req_ready = 2'b01;
                            w_gnt_port  = port_idx_t'(0);
                        end else begin
                            o_req_ready = 2'b10;
                            w_gnt_port  = port_idx_t'(1);
                        end
                    end
                    default: begin
                        o_req_ready = 2'b00;
                    end
                endcase

                if (w_gnt_port == port_idx_t'(1)) begin
                    w_mem_addr = i_req_addr[ADDR_WIDTH +: ADDR_WIDTH];
                    w_mem_data = i_req_wdata[DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    w_mem_addr = i_req_addr[0 +: ADDR_WIDTH];
                    w_mem_data = i_req_wdata[0 +: DATA_WIDTH];
                end
                w_mem_write = (|o_req_ready) & i_req_write[w_gnt_port];
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_any_gnt   = |o_req_ready;
    assign w_gnt_write = i_req_write[w_gnt_port];

    // ------------------------------------------------------------------
    // Init counter, round-robin pointer and single-entry response stage
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_addr  <= '0;
            r_last_grant <= port_idx_t'(1);
            r_rsp_vld    <= 1'b0;
            r_rsp_port   <= '0;
        end else begin
            if (r_state == INIT) begin
                r_init_addr <= r_init_addr + (ADDR_WIDTH+1)'(1);
            end
            if (w_any_gnt) begin
                r_last_grant <= w_gnt_port;
                r_rsp_port   <= w_gnt_port;
            end
            r_rsp_vld <= w_any_gnt & ~w_gnt_write;
        end
    end

    always_comb begin
        o_rsp_valid             = '0;
        o_rsp_valid[r_rsp_port] = r_rsp_vld;
    end

    assign o_init_done = (r_state == SERVE);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .i_clk   (i_clk),
        .i_write (w_mem_write),
        .i_addr  (w_mem_addr),
        .i_data  (w_mem_data),
        .o_data  (o_rsp_data)
    );

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          i_clk;
    logic          i_rst_n;
    logic [1:0]    i_req_valid;
    logic [1:0]    i_req_write;
    logic [2*AW-1:0] i_req_addr;
    logic [2*DW-1:0] i_req_wdata;
    logic [1:0]    o_req_ready;
    logic [1:0]    o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_init_done;

    int n_checks = 0;
    int n_fails  = 0;

    sram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_init_done (o_init_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int port, input logic vld, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        i_req_valid[port]         = vld;
        i_req_write[port]         = wr;
        i_req_addr[port*AW +: AW] = addr;
        i_req_wdata[port*DW +: DW] = data;
    endtask

    task automatic wait_init(input string tag);
        for (int k = 1; k <= 31; k++) begin
            @(negedge i_clk);
            check_eq($sformatf("%s_busy_done_c%0d", tag, k), 64'(o_init_done), 64'd0);
            check_eq($sformatf("%s_busy_ready_c%0d", tag, k), 64'(o_req_ready), 64'd0);
        end
        @(negedge i_clk);
        check_eq({tag, "_done_c32"}, 64'(o_init_done), 64'd1);
    endtask

    initial begin
        logic [1:0]  exp_gnt;
        logic [1:0]  prev_gnt;
        logic [31:0] prev_data;

        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_write = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge i_clk);
        check_eq("rst_ready", 64'(o_req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_eq("rst_init_done", 64'(o_init_done), 64'd0);

        // Port 0 requests a read of address 0 all through INIT: stalled.
        set_req(0, 1'b1, 1'b0, 5'd0, 32'h0);
        i_rst_n = 1'b1;
        wait_init("init1");
        check_eq("init1_first_grant", 64'(o_req_ready), 64'd1);

        // ---------------- zero-fill readback ----------------
        for (int a = 1; a <= 32; a++) begin
            @(negedge i_clk);
            check_eq($sformatf("zero_rsp_valid_a%0d", a-1), 64'(o_rsp_valid), 64'd1);
            check_eq($sformatf("zero_rsp_data_a%0d", a-1), 64'(o_rsp_data), 64'd0);
            if (a < 32) begin
                set_req(0, 1'b1, 1'b0, 5'(a), 32'h0);
                #1;
                check_eq($sformatf("zero_ready_a%0d", a), 64'(o_req_ready), 64'd1);
            end else begin
                set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
            end
        end

        // ---------------- write then read-after-write ----------------
        @(negedge i_clk);
        set_req(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check_eq("raw_wr_ready", 64'(o_req_ready), 64'd1);
        @(negedge i_clk);
        check_eq("raw_wr_no_rsp", 64'(o_rsp_valid), 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd5, 32'h0);
        #1;
        check_eq("raw_rd_ready", 64'(o_req_ready), 64'd2);
        @(negedge i_clk);
        check_eq("raw_rsp_valid", 64'(o_rsp_valid), 64'd2);
        check_eq("raw_rsp_data", 64'(o_rsp_data), 64'hDEADBEEF);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);

        // ---------------- both ports reading: alternation ----------------
        // Port 1 won last, so port 0 takes the first tie.
        @(negedge i_clk);
        set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd6, 32'h0);
        for (int i = 0; i < 6; i++) begin
            exp_gnt   = (i % 2 == 0) ? 2'b01 : 2'b10;
            prev_data = (i % 2 == 0) ? 32'hDEADBEEF : 32'h0;
            #1;
            check_eq($sformatf("rr_ready_%0d", i), 64'(o_req_ready), 64'(exp_gnt));
            @(negedge i_clk);
            check_eq($sformatf("rr_rsp_valid_%0d", i), 64'(o_rsp_valid), 64'(exp_gnt));
            check_eq($sformatf("rr_rsp_data_%0d", i), 64'(o_rsp_data), 64'(prev_data));
        end
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);

        // ---------------- port 1 alone, then tie ----------------
        @(negedge i_clk);
        set_req(1, 1'b1, 1'b0, 5'd7, 32'h0);
        prev_gnt = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
            exp_gnt = (i == 3) ? 2'b01 : 2'b10;
            #1;
            check_eq($sformatf("solo_ready_%0d", i), 64'(o_req_ready), 64'(exp_gnt));
            check_eq($sformatf("solo_prev_rsp_%0d", i), 64'(o_rsp_valid), 64'(prev_gnt));
            prev_gnt = exp_gnt;
            @(negedge i_clk);
        end
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 32'h0);

        // ---------------- async reset with a read in flight ----------------
        @(negedge i_clk);
        set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
        #1;
        check_eq("arst_pre_ready", 64'(o_req_ready), 64'd1);
        @(posedge i_clk);
        #2;
        check_eq("arst_pending_rsp", 64'(o_rsp_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_eq("arst_rsp_cleared", 64'(o_rsp_valid), 64'd0);
        check_eq("arst_ready_cleared", 64'(o_req_ready), 64'd0);
        check_eq("arst_done_cleared", 64'(o_init_done), 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_init("init2");
        set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
        #1;
        check_eq("arst_rd_ready", 64'(o_req_ready), 64'd1);
        @(negedge i_clk);
        set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
        check_eq("arst_rd_valid", 64'(o_rsp_valid), 64'd1);
        check_eq("arst_rd_data", 64'(o_rsp_data), 64'd0);

        repeat (2) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
